alu_op_sequencer: RTL and testbench

//  Issue side of the ALU result multiplexer. Accepts one RV32I ALU operation per handshake.

---
 rtl/alu_op_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issue side of the ALU result multiplexer: accepts one RV32I ALU op per handshake,
// drives registered operands/controls to the ALU, captures and returns the result.
module alu_op_sequencer #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             is_imm,
  input  logic [N-1:0]     rs1_val,
  input  logic [N-1:0]     rs2_val,
  input  logic [N-1:0]     imm,
  output logic [N-1:0]     alu_x,
  output logic [N-1:0]     alu_y,
  output logic             alu_sub,
  output logic             alu_s0,
  output logic             alu_s1,
  input  logic [N-1:0]     alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     alu_x_q, alu_x_d;
  logic [N-1:0]     alu_y_q, alu_y_d;
  logic             alu_sub_q, alu_sub_d;
  logic [1:0]       sel_q, sel_d;
  logic             illegal_q, illegal_d;
  logic [N-1:0]     out_result_q, out_result_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [1:0]       dec_sel;
  logic             dec_sub;
  logic             dec_illegal;

  // Only register-register ADD may subtract; ADDI has no SUB encoding.
  always_comb begin
    dec_sel     = 2'b00;
    dec_sub     = 1'b0;
    dec_illegal = 1'b0;
    unique case (funct3)
      3'b000:  dec_sub = ~is_imm & funct7_5;
      3'b111:  dec_sel = 2'b01;
      3'b110:  dec_sel = 2'b10;
      3'b100:  dec_sel = 2'b11;
      default: dec_illegal = 1'b1;
    endcase
  end

  // NOTE: every always_comb output starts from its held value so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    alu_sub_d    = alu_sub_q;
    sel_d        = sel_q;
    illegal_d    = illegal_q;
    out_result_d = out_result_q;
    op_count_d   = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          alu_x_d   = rs1_val;
          alu_y_d   = is_imm ? imm : rs2_val;
          alu_sub_d = dec_sub;
          sel_d     = dec_sel;
          illegal_d = dec_illegal;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        out_result_d = illegal_q ? '0 : alu_result;
        state_d      = DONE;
      end
      DONE: begin
        if (out_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      alu_sub_q    <= 1'b0;
      sel_q        <= 2'b00;
      illegal_q    <= 1'b0;
      out_result_q <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      alu_sub_q    <= alu_sub_d;
      sel_q        <= sel_d;
      illegal_q    <= illegal_d;
      out_result_q <= out_result_d;
      op_count_q   <= op_count_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign alu_x       = alu_x_q;
  assign alu_y       = alu_y_q;
  assign alu_sub     = alu_sub_q;
  assign alu_s1      = sel_q[1];
  assign alu_s0      = sel_q[0];
  assign out_illegal = illegal_q;
  assign out_result  = out_result_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: behavioural ALU mux model, handshake timing,
// backpressure, illegal ops, counter wrap (second instance with CNT_W=2) and async reset.
module tb_alu_op_sequencer;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, funct7_5, is_imm, out_ready;
  logic [2:0]    funct3;
  logic [N-1:0]  rs1_val, rs2_val, imm;

  logic          in_ready, alu_sub, alu_s0, alu_s1, out_valid, out_illegal;
  logic [N-1:0]  alu_x, alu_y, alu_result, out_result;
  logic [15:0]   op_count;

  logic          w2_in_ready, w2_alu_sub, w2_alu_s0, w2_alu_s1, w2_out_valid, w2_out_illegal;
  logic [N-1:0]  w2_alu_x, w2_alu_y, w2_alu_result, w2_out_result;
  logic [1:0]    w2_op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  function automatic logic [N-1:0] alu_model(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic sub, input logic s1, input logic s0);
    unique case ({s1, s0})
      2'b00:   return sub ? x - y : x + y;
      2'b01:   return x & y;
      2'b10:   return x | y;
      default: return x ^ y;
    endcase
  endfunction

  assign alu_result    = alu_model(alu_x, alu_y, alu_sub, alu_s1, alu_s0);
  assign w2_alu_result = alu_model(w2_alu_x, w2_alu_y, w2_alu_sub, w2_alu_s1, w2_alu_s0);

  alu_op_sequencer #(.N(N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .funct7_5(funct7_5), .is_imm(is_imm),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sub(alu_sub), .alu_s0(alu_s0), .alu_s1(alu_s1),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_illegal(out_illegal), .op_count(op_count)
  );

  alu_op_sequencer #(.N(N), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w2_in_ready),
    .funct3(funct3), .funct7_5(funct7_5), .is_imm(is_imm),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .alu_x(w2_alu_x), .alu_y(w2_alu_y), .alu_sub(w2_alu_sub), .alu_s0(w2_alu_s0),
    .alu_s1(w2_alu_s1), .alu_result(w2_alu_result), .out_valid(w2_out_valid),
    .out_ready(out_ready), .out_result(w2_out_result), .out_illegal(w2_out_illegal),
    .op_count(w2_op_count)
  );

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".in_ready"},    N'(in_ready), 1);
    check({tag, ".out_valid"},   N'(out_valid), 0);
    check({tag, ".out_illegal"}, N'(out_illegal), 0);
    check({tag, ".op_count"},    N'(op_count), 0);
    check({tag, ".alu_x"},       alu_x, 0);
    check({tag, ".alu_y"},       alu_y, 0);
    check({tag, ".out_result"},  out_result, 0);
    check({tag, ".ctrl"},        N'({alu_sub, alu_s1, alu_s0}), 0);
  endtask

  // One operation: issue, check EXEC cycle, result at k+2, optional stall, then consume.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic f7, input logic ii,
                        input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] im,
                        input logic [N-1:0] exp_y, input logic [1:0] exp_sel, input logic exp_sub,
                        input logic [N-1:0] exp_res, input logic exp_ill, input int stall);
    @(negedge clk);
    in_valid = 1'b1; funct3 = f3; funct7_5 = f7; is_imm = ii;
    rs1_val = a; rs2_val = b; imm = im;
    @(posedge clk); #1;
    check({tag, ".exec_in_ready"}, N'(in_ready), 0);
    check({tag, ".exec_out_valid"}, N'(out_valid), 0);
    check({tag, ".alu_x"}, alu_x, a);
    check({tag, ".alu_y"}, alu_y, exp_y);
    check({tag, ".sel"}, N'({alu_s1, alu_s0}), N'(exp_sel));
    check({tag, ".sub"}, N'(alu_sub), N'(exp_sub));
    @(negedge clk);
    rs1_val = ~a; rs2_val = ~b; imm = ~im; funct3 = 3'b111;
    @(posedge clk); #1;
    check({tag, ".out_valid"}, N'(out_valid), 1);
    check({tag, ".out_result"}, out_result, exp_res);
    check({tag, ".out_illegal"}, N'(out_illegal), N'(exp_ill));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, ".stall_valid"}, N'(out_valid), 1);
      check({tag, ".stall_result"}, out_result, exp_res);
      check({tag, ".stall_in_ready"}, N'(in_ready), 0);
      check({tag, ".stall_alu_x"}, alu_x, a);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    exp_count++;
    check({tag, ".post_in_ready"}, N'(in_ready), 1);
    check({tag, ".post_out_valid"}, N'(out_valid), 0);
    check({tag, ".op_count"}, N'(op_count), N'(exp_count));
    check({tag, ".op_count_w2"}, N'(w2_op_count), N'(exp_count % 4));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; funct3 = 3'b000;
    funct7_5 = 1'b0; is_imm = 1'b0; rs1_val = '0; rs2_val = '0; imm = '0;
    #12;
    check_reset_values("reset");
    @(negedge clk); rst_n = 1'b1;

    // Idle with no request: nothing moves.
    rs1_val = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check("idle.in_ready", N'(in_ready), 1);
    check("idle.alu_x", alu_x, 0);

    //     tag     f3      f7  imm  rs1            rs2            imm            exp_y          sel    sub  result         ill stall
    run_op("add",  3'b000, 0, 0, 32'd5,         32'd7,         32'd0,         32'd7,         2'b00, 0, 32'd12,        0, 0);
    run_op("sub",  3'b000, 1, 0, 32'd5,         32'd7,         32'd0,         32'd7,         2'b00, 1, 32'hFFFF_FFFE, 0, 0);
    run_op("addi", 3'b000, 1, 1, 32'd5,         32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 0, 32'd4,         0, 0);
    run_op("and",  3'b111, 0, 0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0,         32'h0FF0_0F0F, 2'b01, 0, 32'h00F0_000F, 0, 0);
    run_op("or",   3'b110, 0, 0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0,         32'h0FF0_0F0F, 2'b10, 0, 32'hFFF0_0FFF, 0, 0);
    run_op("xor",  3'b100, 0, 0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0,         32'h0FF0_0F0F, 2'b11, 0, 32'hFF00_0FF0, 0, 0);
    run_op("bp",   3'b000, 0, 0, 32'd100,       32'd23,        32'd0,         32'd23,        2'b00, 0, 32'd123,       0, 10);
    run_op("ill",  3'b001, 1, 0, 32'd5,         32'd7,         32'd0,         32'd7,         2'b00, 0, 32'd0,         1, 0);

    // Async reset while in EXEC: outputs return to reset values without a clock edge.
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'b110; funct7_5 = 1'b0; is_imm = 1'b0;
    rs1_val = 32'h1234_0000; rs2_val = 32'h0000_5678;
    @(posedge clk); #1;
    check("rst_exec.in_ready", N'(in_ready), 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("rst_async");
    check("rst_async.w2_count", N'(w2_op_count), 0);
    @(negedge clk); rst_n = 1'b1;
    exp_count = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_after.out_valid", N'(out_valid), 0);

    run_op("post_rst", 3'b100, 0, 1, 32'h0000_00FF, 32'd0, 32'h0000_0F0F, 32'h0000_0F0F, 2'b11, 0, 32'h0000_0FF0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
